// File: rtl/increment_term_array_gen.sv
// Per-element comparator increment terms L_kn = 2k + 1 + B_n for one scanline.
// Optional build macro INCR_TERM_SATURATE_EN: STEP additions saturate at the max positive value.
module increment_term_array_gen #(
  parameter int unsigned NUM_ELEMENTS = 64,
  parameter int unsigned DW_INPUT     = 8,
  parameter int unsigned DW_INTEGER   = 16,
  parameter int unsigned DW_FRACTION  = 8,
  parameter int unsigned DW_DELTA     = 22,
  parameter int unsigned R0_SCALE     = 8312,
  parameter int unsigned K_STEP       = 1,
  parameter int unsigned OUT_LSB      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          configure,
  input  logic [DW_INPUT-1:0]           r_0,
  input  logic [DW_DELTA-1:0]           delta_term,
  input  logic                          delta_valid,
  output logic                          delta_ack,
  input  logic                          ack,
  input  logic                          final_scanpoint,
  output logic [NUM_ELEMENTS-1:0][DW_INTEGER+DW_FRACTION-OUT_LSB:0] output_terms,
  output logic                          ready,
  output logic                          done_configuring,
  output logic [15:0]                   point_index
);

  localparam int unsigned HALF = NUM_ELEMENTS / 2;
  localparam int unsigned W    = DW_INTEGER + DW_FRACTION + 1;
  localparam int unsigned JW   = $clog2(HALF + 1);
  localparam logic [W-1:0] STEP_INC = W'(2 * K_STEP) << DW_FRACTION;
  localparam logic [W-1:0] ONE_FRAC = W'(1) << DW_FRACTION;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_WAIT, S_STEP} state_t;

  state_t                state_q, state_d;
  logic [HALF:0][W-1:0]  pos_q, pos_d;
  logic [HALF-1:0][W-1:0] neg_q, neg_d;
  logic [JW-1:0]         j_q, j_d;
  logic [DW_INPUT-1:0]   r0_q, r0_d;
  logic [W-1:0]          delta_q, delta_d;
  logic [15:0]           pidx_q, pidx_d;
  logic                  done_q, done_d;
  logic                  dack_q, dack_d;
  logic [W-1:0]          b0;

  // Adding a positive constant can only overflow upward: operand non-negative, sum negative.
  function automatic logic [W-1:0] step_add(input logic [W-1:0] x);
    logic [W-1:0] s;
    s = x + STEP_INC;
`ifdef INCR_TERM_SATURATE_EN
    if (!x[W-1] && s[W-1]) s = {1'b0, {(W-1){1'b1}}};
`endif
    return s;
  endfunction

  always_comb begin
    b0 = W'(r0_q) * W'(R0_SCALE) + ONE_FRAC;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    j_d     = j_q;
    r0_d    = r0_q;
    delta_d = delta_q;
    pidx_d  = pidx_q;
    done_d  = done_q;
    dack_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        pos_d  = '0;
        neg_d  = '0;
        pidx_d = '0;
        done_d = 1'b0;
      end
      S_LOAD: begin
        if (delta_valid) begin
          delta_d  = W'(signed'(delta_term));
          dack_d   = 1'b1;
          pos_d[0] = b0;
          neg_d[0] = b0;
          j_d      = JW'(1);
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        for (int unsigned i = 1; i <= HALF; i++) begin
          if (j_q == JW'(i)) pos_d[i] = pos_q[i-1] - delta_q;
        end
        for (int unsigned i = 1; i < HALF; i++) begin
          if (j_q == JW'(i)) neg_d[i] = neg_q[i-1] + delta_q;
        end
        if (j_q == JW'(HALF)) begin
          done_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_WAIT: begin
        if (ack) begin
          if (final_scanpoint) begin
            pos_d   = '0;
            neg_d   = '0;
            pidx_d  = '0;
            done_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        for (int unsigned i = 0; i <= HALF; i++) pos_d[i] = step_add(pos_q[i]);
        for (int unsigned i = 0; i < HALF; i++)  neg_d[i] = step_add(neg_q[i]);
        pidx_d  = pidx_q + 16'(K_STEP);
        state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    // Restart overrides whatever the current state decided, including a same-cycle ack.
    if (configure) begin
      pos_d   = '0;
      neg_d   = '0;
      j_d     = '0;
      delta_d = '0;
      pidx_d  = '0;
      done_d  = 1'b0;
      dack_d  = 1'b0;
      r0_d    = r_0;
      state_d = S_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      neg_q   <= '0;
      j_q     <= '0;
      r0_q    <= '0;
      delta_q <= '0;
      pidx_q  <= '0;
      done_q  <= 1'b0;
      dack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      j_q     <= j_d;
      r0_q    <= r0_d;
      delta_q <= delta_d;
      pidx_q  <= pidx_d;
      done_q  <= done_d;
      dack_q  <= dack_d;
    end
  end

  always_comb begin
    output_terms = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      output_terms[HALF+i]   = pos_q[i+1][W-1:OUT_LSB];
      output_terms[HALF-1-i] = neg_q[i][W-1:OUT_LSB];
    end
  end

  assign ready            = (state_q == S_WAIT);
  assign done_configuring = done_q;
  assign delta_ack        = dack_q;
  assign point_index      = pidx_q;

endmodule

// File: tb/tb_increment_term_array_gen.sv
// Directed bench for increment_term_array_gen: default, K_STEP=3 and narrow-integer instances.
module tb_increment_term_array_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg, ack;
  logic        final_sp;
  logic [7:0]  r_0;
  logic [21:0] delta_term;
  logic        delta_valid;

  logic [2:0]  rdy, done, dack;
  logic [15:0] pi0, pi1, pi2;
  logic [63:0][20:0] ot0, ot1;
  logic [63:0][8:0]  ot2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int    dut;
    int    idx;
    int    val;
    string tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  increment_term_array_gen dut0 (
    .clk(clk), .rst_n(rst_n), .configure(cfg[0]), .r_0(r_0),
    .delta_term(delta_term), .delta_valid(delta_valid), .delta_ack(dack[0]),
    .ack(ack[0]), .final_scanpoint(final_sp), .output_terms(ot0),
    .ready(rdy[0]), .done_configuring(done[0]), .point_index(pi0)
  );

  increment_term_array_gen #(.K_STEP(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .configure(cfg[1]), .r_0(r_0),
    .delta_term(delta_term), .delta_valid(delta_valid), .delta_ack(dack[1]),
    .ack(ack[1]), .final_scanpoint(final_sp), .output_terms(ot1),
    .ready(rdy[1]), .done_configuring(done[1]), .point_index(pi1)
  );

  increment_term_array_gen #(.DW_INTEGER(4), .R0_SCALE(256)) dut2 (
    .clk(clk), .rst_n(rst_n), .configure(cfg[2]), .r_0(r_0),
    .delta_term(delta_term), .delta_valid(delta_valid), .delta_ack(dack[2]),
    .ack(ack[2]), .final_scanpoint(final_sp), .output_terms(ot2),
    .ready(rdy[2]), .done_configuring(done[2]), .point_index(pi2)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // idx < 0 selects point_index, otherwise an output term (sign-extended).
  function automatic logic signed [31:0] obs_of(input int d, input int idx);
    logic signed [31:0] r;
    r = 0;
    case (d)
      0: if (idx < 0) r = 32'(pi0); else r = $signed(ot0[idx]);
      1: if (idx < 0) r = 32'(pi1); else r = $signed(ot1[idx]);
      default: if (idx < 0) r = 32'(pi2); else r = $signed(ot2[idx]);
    endcase
    return r;
  endfunction

  task automatic push(input int d, input int idx, input int val, input string tag);
    exp_t e;
    e.dut = d; e.idx = idx; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_corners(input int d, input int val, input string tag);
    int ids[4] = '{0, 31, 32, 63};
    foreach (ids[k]) push(d, ids[k], val, tag);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_of(e.dut, e.idx), e.val);
    end
  endtask

  task automatic start_cfg(input int d, input logic [7:0] r0);
    @(negedge clk);
    cfg[d] = 1'b1; r_0 = r0;
    @(negedge clk);
    cfg[d] = 1'b0;
  endtask

  task automatic give_delta(input int d, input logic [21:0] dl);
    delta_term = dl; delta_valid = 1'b1;
    @(negedge clk);
    delta_valid = 1'b0;
    chk("delta_ack_pulse", 32'(dack[d]), 1);
  endtask

  task automatic wait_ready(input int d, input int start, output int lat);
    lat = start;
    while (!rdy[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack(input int d, input logic fin);
    ack[d] = 1'b1; final_sp = fin;
    @(negedge clk);
    ack[d] = 1'b0; final_sp = 1'b0;
  endtask

  initial begin
    int lat;
    int b0_10, e_s1, raw;
    cfg = '0; ack = '0; final_sp = 1'b0; r_0 = '0;
    delta_term = '0; delta_valid = 1'b0; rst_n = 1'b0;
    b0_10 = 256 + 10 * 8312;
    e_s1  = b0_10 >>> 4;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(rdy[0]), 0);
    chk("reset_done", 32'(done[0]), 0);
    chk("reset_dack", 32'(dack[0]), 0);
    chk("reset_pidx", obs_of(0, -1), 0);
    chk("reset_term0", obs_of(0, 0), 0);
    chk("reset_term63", obs_of(0, 63), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // r_0 = 10, delta = 0; an ack while in LOAD must be ignored
    start_cfg(0, 8'd10);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    chk("ack_in_load_ignored", 32'(rdy[0]), 0);
    give_delta(0, 22'd0);
    @(negedge clk);
    chk("delta_ack_one_cycle", 32'(dack[0]), 0);
    wait_ready(0, 2, lat);
    chk("fill_latency", lat, 33);
    chk("done_after_fill", 32'(done[0]), 1);
    push_corners(0, e_s1, "s1_term");
    push(0, 17, e_s1, "s1_term17");
    push(0, -1, 0, "s1_pidx");
    drain();

    delta_valid = 1'b1;
    @(negedge clk);
    delta_valid = 1'b0;
    chk("no_dack_outside_load", 32'(dack[0]), 0);

    do_ack(0, 1'b0);
    chk("ready_low_in_step", 32'(rdy[0]), 0);
    @(negedge clk);
    chk("ready_after_step", 32'(rdy[0]), 1);
    push_corners(0, (b0_10 + 512) >>> 4, "s1_step_term");
    push(0, -1, 1, "s1_step_pidx");
    drain();

    // final scanpoint back to IDLE, then a fresh scanline
    do_ack(0, 1'b1);
    chk("idle_ready", 32'(rdy[0]), 0);
    chk("idle_done", 32'(done[0]), 0);
    push_corners(0, 0, "idle_term");
    push(0, -1, 0, "idle_pidx");
    drain();
    start_cfg(0, 8'd10);
    give_delta(0, 22'd0);
    wait_ready(0, 1, lat);
    chk("refill_latency", lat, 33);
    push_corners(0, e_s1, "s3_term");
    drain();

    // r_0 = 0, delta = 256, issued as an abort from WAIT
    start_cfg(0, 8'd0);
    chk("done_cleared_on_abort", 32'(done[0]), 0);
    give_delta(0, 22'd256);
    wait_ready(0, 1, lat);
    push(0, 31, 16, "s2_t31");
    push(0, 32, 0, "s2_t32");
    push(0, 0, 512, "s2_t0");
    push(0, 63, -496, "s2_t63");
    push(0, 33, -16, "s2_t33");
    drain();

    // abort during FILL; the second run must show no trace of the first delta
    start_cfg(0, 8'd10);
    give_delta(0, 22'd256);
    repeat (5) @(negedge clk);
    chk("mid_fill_not_ready", 32'(rdy[0]), 0);
    start_cfg(0, 8'd20);
    give_delta(0, 22'd0);
    wait_ready(0, 1, lat);
    chk("abort_refill_latency", lat, 33);
    push_corners(0, (256 + 20 * 8312) >>> 4, "s4_term");
    drain();

    // K_STEP = 3
    start_cfg(1, 8'd10);
    give_delta(1, 22'd0);
    wait_ready(1, 1, lat);
    chk("k3_latency", lat, 33);
    for (int s = 1; s <= 3; s++) begin
      do_ack(1, 1'b0);
      @(negedge clk);
      push(1, -1, 3 * s, "k3_pidx");
      push(1, 0, e_s1 + 96 * s, "k3_t0");
      push(1, 63, e_s1 + 96 * s, "k3_t63");
      drain();
    end

    // narrow integer field: step overflow behaviour
    start_cfg(2, 8'd14);
    give_delta(2, 22'd0);
    wait_ready(2, 1, lat);
    chk("narrow_latency", lat, 33);
    push_corners(2, (256 + 14 * 256) >>> 4, "narrow_term");
    drain();
    do_ack(2, 1'b0);
    @(negedge clk);
    raw = 256 + 14 * 256 + 512;
`ifdef INCR_TERM_SATURATE_EN
    if (raw > 4095) raw = 4095;
`else
    if (raw > 4095) raw = raw - 8192;
`endif
    push_corners(2, raw >>> 4, "narrow_step_term");
    drain();

    // asynchronous reset while in WAIT
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready2", 32'(rdy[2]), 0);
    chk("async_rst_done2", 32'(done[2]), 0);
    chk("async_rst_term2", obs_of(2, 63), 0);
    chk("async_rst_pidx1", obs_of(1, -1), 0);
    chk("async_rst_term0", obs_of(0, 63), 0);
    chk("async_rst_ready0", 32'(rdy[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/increment_term_array_gen.md
Name: increment_term_array_gen

Overview:
- Generates the per-element comparator increment terms L_kn = 2k + 1 + B_n for one scanline, where B_n = 2·R_0·f_s/v_s ∓ n·Δ and Δ = 2·p·f_s/v_s·cos(angle).
- Parametrised successor of the fixed 64-element term calculator. It adds:
  - generic element count and widths;
  - an external Δ handshake, so the CORDIC is shared at top level;
  - a configurable point stride;
  - a point index output;
  - abort/restart on configure.
- Sits between the shared cosine unit and the per-element delay comparators.

Parameters:
- NUM_ELEMENTS, 64, element count; even, ≥2. HALF = NUM_ELEMENTS/2.
- DW_INPUT, 8, width of r_0.
- DW_INTEGER, 16, integer bits of the internal term.
- DW_FRACTION, 8, fractional bits of term and Δ.
- DW_DELTA, 22, width of signed Δ input.
- R0_SCALE, 8312, unsigned 16-bit constant 2·f_s/v_s in Q.DW_FRACTION (≈32.47).
- K_STEP, 1, points advanced per ack. Each step adds 2·K_STEP.
- OUT_LSB, 4, LSBs dropped on output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- configure  in  1  start/restart scanline
- r_0  in  DW_INPUT  unsigned start radius, sampled on configure
- delta_term  in  DW_DELTA  signed Δ, Q.DW_FRACTION
- delta_valid  in  1  delta_term valid
- delta_ack  out  1  one-cycle pulse when Δ is latched
- ack  in  1  outputs consumed
- final_scanpoint  in  1  qualifies ack as the last point
- output_terms  out  NUM_ELEMENTS × (DW_INTEGER+DW_FRACTION+1−OUT_LSB)  signed terms
- ready  out  1  output_terms valid
- done_configuring  out  1  high from the end of the first fill until IDLE
- point_index  out  16  current k, counting by K_STEP

Behaviour:
Registers and arithmetic:
- Internal term width W = DW_INTEGER+DW_FRACTION+1, signed, two's complement, wrap-around arithmetic.
- Registers: pos[0..HALF], neg[0..HALF−1].
- Output mapping: output_terms[HALF+i] = pos[i+1][W−1:OUT_LSB] and output_terms[HALF−1−i] = neg[i][W−1:OUT_LSB], for i = 0..HALF−1.
- Δ is sign-extended to W.

Reset (rst_n low, asynchronous):
- state = IDLE.
- All term registers = 0; ready, done_configuring and delta_ack = 0; point_index = 0.

FSM states: IDLE, LOAD, FILL, WAIT, STEP.
- IDLE:
  - Registers cleared as at reset.
  - configure → latch r_0, go to LOAD.
- LOAD:
  - Wait for delta_valid.
  - On delta_valid: latch Δ; pulse delta_ack for one cycle; set pos[0] = neg[0] = B0 = (1<<DW_FRACTION) + r_0·R0_SCALE, truncated to W; clear the fill index j = 1; go to FILL.
  - Δ = 0 is legal (angle 90°).
- FILL:
  - One element pair per cycle: pos[j] = pos[j−1] − Δ, neg[j] = neg[j−1] + Δ (neg only while j < HALF).
  - Lasts HALF cycles.
  - On the cycle j = HALF, set done_configuring = 1 and go to WAIT.
- WAIT:
  - ready = 1, combinationally tied to state == WAIT.
  - output_terms are stable.
  - ack & final_scanpoint → IDLE.
  - ack alone → STEP.
- STEP:
  - One cycle. Every pos/neg register += 2·K_STEP·2^DW_FRACTION.
  - point_index += K_STEP.
  - Go to WAIT.

Latency:
- From delta_valid to ready is HALF+1 cycles.
- From ack to the next ready is 2 cycles (ready low during STEP).

Boundary conditions:
- configure in any non-IDLE state aborts: clear registers and point_index, latch r_0, go to LOAD.
- configure and ack in the same cycle: configure wins.
- ack outside WAIT is ignored.
- delta_valid outside LOAD is ignored (no delta_ack).
- point_index wraps at 2^16.
- Reset mid-FILL or mid-WAIT returns to the full reset state immediately.

Optional Feature:
- Macro: INCR_TERM_SATURATE_EN.
- Defined: STEP additions saturate at the maximum positive W-bit value, 2^(W−1)−1. Registers already saturated stay there.
- Undefined: STEP additions wrap modulo 2^W.
- FILL arithmetic wraps in both builds.

Test Plan:
1. Defaults, r_0 = 10, Δ = 0 → B0 = 83376. After HALF+1 = 33 cycles, ready = 1 and all 64 output_terms = 5211. Ack once → after 2 cycles, all = 5243 and point_index = 1.
2. Defaults, r_0 = 0, Δ = 256 → output_terms[31] = 16, [32] = 0, [0] = 512, [63] = −496.
3. Ack with final_scanpoint = 1 → next cycle state is IDLE; ready, done_configuring and outputs are 0. A new configure with r_0 = 10 reproduces scenario 1.
4. Pulse configure during FILL with r_0 = 20, Δ = 0 → restart. Outputs equal (256 + 166240) >> 4 = 10406 after a fresh fill, with no residue from the first run.
5. Set K_STEP = 3, three acks → point_index = 9. Terms rise by 3 × 512 = 1536 per step (96 per step at the output).
6. Set DW_INTEGER = 4, R0_SCALE = 256, r_0 = 14, Δ = 0 → B0 = 3840, ack once:
   - with INCR_TERM_SATURATE_EN: internal 4095, output 255;
   - without: internal −3840, output −240.
   - Also assert rst_n low mid-WAIT → all outputs 0 asynchronously.
